// File: rtl/aes128_pkg.sv
// AES-128 shared definitions: S-box, GF(2^8) helpers, state typedef, byte indexing
// and the one-hot FSM encoding used by the cipher core.
package aes128_pkg;

   localparam int         NR       = 10;
   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef logic [127:0] blockT;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RUN  = 3'b010,
      ST_DONE = 3'b100
   } fsmStateT;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gfMul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic int byteLsb(input int col, input int row);
      return 32 * col + 8 * row;
   endfunction

   function automatic logic [7:0] getByte(input blockT s, input int col, input int row);
      return s[byteLsb(col, row) +: 8];
   endfunction

endpackage

// File: rtl/aes128_round.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when iFinal),
// then AddRoundKey.
module aes128_round
   import aes128_pkg::*;
(
   input  logic [127:0] iState,
   input  logic [127:0] iRoundKey,
   input  logic         iFinal,
   output logic [127:0] oState
);

   blockT shifted;
   blockT mixed;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      shifted = '0;
      mixed   = '0;
      // Row r of output column c is taken from input column c+r (left rotation by r).
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[byteLsb(c, r) +: 8] = SBOX[getByte(iState, (c + r) % 4, r)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            mixed[byteLsb(c, r) +: 8] = gfMul2(getByte(shifted, c, r))
                                      ^ gfMul3(getByte(shifted, c, (r + 1) % 4))
                                      ^ getByte(shifted, c, (r + 2) % 4)
                                      ^ getByte(shifted, c, (r + 3) % 4);
         end
      end
      oState = (iFinal ? shifted : mixed) ^ iRoundKey;
   end

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, stalls while the current round key
// is not ready. Defining AES128_STALL_CNT_EN adds oStallCnt, a saturating stall-cycle counter.
module aes128_cipher_core
   import aes128_pkg::*;
`ifdef AES128_STALL_CNT_EN
#(
   parameter int STALL_CNT_W = 16
)
`endif
(
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iStart,
   input  logic         iLastBlock,
   input  logic [127:0] iData,
   input  logic [10:0]  iKeyRoundReady,
   input  logic [127:0] iKeyRound00,
   input  logic [127:0] iKeyRound01,
   input  logic [127:0] iKeyRound02,
   input  logic [127:0] iKeyRound03,
   input  logic [127:0] iKeyRound04,
   input  logic [127:0] iKeyRound05,
   input  logic [127:0] iKeyRound06,
   input  logic [127:0] iKeyRound07,
   input  logic [127:0] iKeyRound08,
   input  logic [127:0] iKeyRound09,
   input  logic [127:0] iKeyRound10,
   output logic         oBusy,
   output logic         oDone,
   output logic [127:0] oData,
   output logic         oKeyEnd
`ifdef AES128_STALL_CNT_EN
  ,output logic [STALL_CNT_W-1:0] oStallCnt
`endif
);

   fsmStateT   fsmState, fsmNext;
   logic [3:0] rnd, rndNext;
   blockT      stateReg, stateNext, dataNext, roundKey, roundOut;
   logic       lastBlock, lastNext, keyReady, finalRnd;

   always_comb begin
      roundKey = iKeyRound00;
      keyReady = iKeyRoundReady[0];
      case (rnd)
         4'd1:    begin roundKey = iKeyRound01; keyReady = iKeyRoundReady[1];  end
         4'd2:    begin roundKey = iKeyRound02; keyReady = iKeyRoundReady[2];  end
         4'd3:    begin roundKey = iKeyRound03; keyReady = iKeyRoundReady[3];  end
         4'd4:    begin roundKey = iKeyRound04; keyReady = iKeyRoundReady[4];  end
         4'd5:    begin roundKey = iKeyRound05; keyReady = iKeyRoundReady[5];  end
         4'd6:    begin roundKey = iKeyRound06; keyReady = iKeyRoundReady[6];  end
         4'd7:    begin roundKey = iKeyRound07; keyReady = iKeyRoundReady[7];  end
         4'd8:    begin roundKey = iKeyRound08; keyReady = iKeyRoundReady[8];  end
         4'd9:    begin roundKey = iKeyRound09; keyReady = iKeyRoundReady[9];  end
         4'd10:   begin roundKey = iKeyRound10; keyReady = iKeyRoundReady[10]; end
         default: ;
      endcase
   end

   assign finalRnd = (rnd == LAST_RND);

   aes128_round uRound (
      .iState    (stateReg),
      .iRoundKey (roundKey),
      .iFinal    (finalRnd),
      .oState    (roundOut)
   );

   always_comb begin
      fsmNext   = fsmState;
      rndNext   = rnd;
      stateNext = stateReg;
      lastNext  = lastBlock;
      dataNext  = oData;
      unique case (fsmState)
         ST_IDLE: begin
            if (iStart) begin
               stateNext = iData;
               lastNext  = iLastBlock;
               rndNext   = '0;
               fsmNext   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (keyReady) begin
               stateNext = (rnd == 4'd0) ? (stateReg ^ roundKey) : roundOut;
               rndNext   = rnd + 4'd1;
               if (finalRnd) begin
                  dataNext = roundOut;
                  fsmNext  = ST_DONE;
               end
            end
         end
         ST_DONE: fsmNext = ST_IDLE;
         default: fsmNext = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         fsmState  <= ST_IDLE;
         rnd       <= '0;
         stateReg  <= '0;
         lastBlock <= 1'b0;
         oData     <= '0;
      end else begin
         fsmState  <= fsmNext;
         rnd       <= rndNext;
         stateReg  <= stateNext;
         lastBlock <= lastNext;
         oData     <= dataNext;
      end
   end

   assign oBusy   = (fsmState != ST_IDLE);
   assign oDone   = (fsmState == ST_DONE);
   assign oKeyEnd = oDone & lastBlock;

`ifdef AES128_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stallCnt;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         stallCnt <= '0;
      end else if (fsmState == ST_IDLE && iStart) begin
         stallCnt <= '0;
      end else if (fsmState == ST_RUN && !keyReady && stallCnt != '1) begin
         stallCnt <= stallCnt + STALL_CNT_W'(1);
      end
   end

   assign oStallCnt = stallCnt;
`endif

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Scoreboard bench for aes128_cipher_core: byte-level AES reference model plus a cycle-level
// key-ready schedule; a negedge monitor pops expectations on every oDone.
module tb_aes128_cipher_core;

   localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] ZERO_CT  = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

   logic         iClk = 1'b0;
   logic         iRst = 1'b0;
   logic         iStart = 1'b0;
   logic         iLastBlock = 1'b0;
   logic [127:0] iData = '0;
   logic [10:0]  iKeyRoundReady = '0;
   logic [127:0] rk [11];
   logic         oBusy, oDone, oKeyEnd;
   logic [127:0] oData;
`ifdef AES128_STALL_CNT_EN
   logic [15:0]  oStallCnt;
`endif

   aes128_cipher_core dut (
      .iClk           (iClk),
      .iRst           (iRst),
      .iStart         (iStart),
      .iLastBlock     (iLastBlock),
      .iData          (iData),
      .iKeyRoundReady (iKeyRoundReady),
      .iKeyRound00    (rk[0]),
      .iKeyRound01    (rk[1]),
      .iKeyRound02    (rk[2]),
      .iKeyRound03    (rk[3]),
      .iKeyRound04    (rk[4]),
      .iKeyRound05    (rk[5]),
      .iKeyRound06    (rk[6]),
      .iKeyRound07    (rk[7]),
      .iKeyRound08    (rk[8]),
      .iKeyRound09    (rk[9]),
      .iKeyRound10    (rk[10]),
      .oBusy          (oBusy),
      .oDone          (oDone),
      .oData          (oData),
      .oKeyEnd        (oKeyEnd)
`ifdef AES128_STALL_CNT_EN
     ,.oStallCnt      (oStallCnt)
`endif
   );

   always #5 iClk = ~iClk;

   int cycleCnt = 0;
   always @(posedge iClk) cycleCnt <= cycleCnt + 1;

   typedef struct {
      logic [127:0] data;
      logic         keyEnd;
      int           doneCycle;
      int           stalls;
   } expT;

   expT          sb [$];
   int           nChecks = 0;
   int           nFails  = 0;
   int           nDone   = 0;
   int           nExpected = 0;
   int           readyOff [11];
   logic [127:0] prevData = '0;
   logic [7:0]   sbox [256];
   logic [127:0] modelRk [11];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Polynomial multiply then long-division reduction by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= (15'(a) << i);
      for (int k = 14; k >= 8; k--) if (p[k]) p ^= (15'h11b << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic void buildSbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = '0;
         for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic void expandKey(input logic [127:0] key);
      logic [7:0] w [44][4];
      logic [7:0] t [4];
      logic [7:0] rc = 8'h01;
      for (int b = 0; b < 16; b++) w[b / 4][b % 4] = key[8 * b +: 8];
      for (int j = 4; j < 44; j++) begin
         for (int b = 0; b < 4; b++) t[b] = w[j - 1][b];
         if (j % 4 == 0) begin
            logic [7:0] t0 = t[0];
            t[0] = sbox[t[1]] ^ rc;
            t[1] = sbox[t[2]];
            t[2] = sbox[t[3]];
            t[3] = sbox[t0];
            rc = gmul(rc, 8'h02);
         end
         for (int b = 0; b < 4; b++) w[j][b] = w[j - 4][b] ^ t[b];
      end
      for (int n = 0; n < 11; n++)
         for (int i = 0; i < 16; i++) modelRk[n][8 * i +: 8] = w[4 * n + i / 4][i % 4];
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] ct;
      for (int i = 0; i < 16; i++) s[i] = pt[8 * i +: 8] ^ modelRk[0][8 * i +: 8];
      for (int n = 1; n <= 10; n++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
         if (n < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
               for (int r = 0; r < 4; r++)
                  s[4 * c + r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4]) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
            end
         end
         for (int i = 0; i < 16; i++) s[i] ^= modelRk[n][8 * i +: 8];
      end
      for (int i = 0; i < 16; i++) ct[8 * i +: 8] = s[i];
      return ct;
   endfunction

   function automatic logic [10:0] flagsAt(input int off);
      logic [10:0] f;
      for (int n = 0; n < 11; n++) f[n] = (off >= readyOff[n]);
      return f;
   endfunction

   // Round n may complete in a RUN cycle only once its flag is up; otherwise that cycle is a stall.
   function automatic int modelDone(input int t0, output int stalls);
      int rndM = 0;
      int t = t0 + 1;
      stalls = 0;
      while (rndM <= 10) begin
         if (t - t0 >= readyOff[rndM]) rndM++;
         else stalls++;
         t++;
      end
      return t;
   endfunction

   // Caller is 1 time unit after a rising edge; returns one cycle after the oDone cycle.
   task automatic runBlock(input logic [127:0] pt, input logic [127:0] key, input logic last,
                           input bit useLit, input logic [127:0] litCt, input bit poke);
      expT e;
      int  t0, stalls;
      expandKey(key);
      for (int n = 0; n < 11; n++) rk[n] = modelRk[n];
      t0 = cycleCnt;
      iData = pt;
      iLastBlock = last;
      iStart = 1'b1;
      iKeyRoundReady = flagsAt(0);
      e.data = useLit ? litCt : encrypt(pt);
      e.keyEnd = last;
      e.doneCycle = modelDone(t0, stalls);
      e.stalls = stalls;
      sb.push_back(e);
      nExpected++;
      @(posedge iClk); #1;
      while (cycleCnt <= e.doneCycle) begin
         iKeyRoundReady = flagsAt(cycleCnt - t0);
         iStart = poke && (cycleCnt == t0 + 5 || cycleCnt == e.doneCycle);
         if (iStart) iData = {$urandom(), $urandom(), $urandom(), $urandom()};
         check("busy during block", oBusy, 1'b1);
         if (cycleCnt < e.doneCycle) begin
            check("oData held", oData, prevData);
            check("no early oDone", oDone, 1'b0);
            check("no early oKeyEnd", oKeyEnd, 1'b0);
         end
         @(posedge iClk); #1;
      end
      iStart = 1'b0;
      prevData = e.data;
      check("idle after done", oBusy, 1'b0);
      check("oData after done", oData, e.data);
`ifdef AES128_STALL_CNT_EN
      check("stall count held", oStallCnt, 128'(stalls));
`endif
   endtask

   task automatic setAllReady();
      for (int n = 0; n < 11; n++) readyOff[n] = 0;
   endtask

   initial begin : monitor
      expT e;
      forever begin
         @(negedge iClk);
         if (oDone) begin
            nDone++;
            if (sb.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL unexpected oDone: got pulse, expected none (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("ciphertext", oData, e.data);
               check("oKeyEnd", oKeyEnd, e.keyEnd);
               check("latency", 128'(cycleCnt), 128'(e.doneCycle));
`ifdef AES128_STALL_CNT_EN
               check("stall count", oStallCnt, 128'(e.stalls));
`endif
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [127:0] key, pt;
      int t0;
      buildSbox();
      for (int n = 0; n < 11; n++) rk[n] = '0;
      iRst = 1'b1;
      repeat (2) @(posedge iClk);
      #1;
      check("reset oBusy", oBusy, 1'b0);
      check("reset oDone", oDone, 1'b0);
      check("reset oData", oData, '0);
      check("reset oKeyEnd", oKeyEnd, 1'b0);
      iRst = 1'b0;
      @(posedge iClk); #1;

      setAllReady();
      runBlock(FIPS_PT, FIPS_KEY, 1'b1, 1'b1, FIPS_CT, 1'b0);

      for (int n = 0; n < 11; n++) readyOff[n] = n + 2;
      runBlock(FIPS_PT, FIPS_KEY, 1'b0, 1'b1, FIPS_CT, 1'b0);

      // Back-to-back under one key; starts poked while busy must be ignored.
      setAllReady();
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      runBlock({$urandom(), $urandom(), $urandom(), $urandom()}, key, 1'b0, 1'b0, '0, 1'b1);
      runBlock({$urandom(), $urandom(), $urandom(), $urandom()}, key, 1'b1, 1'b0, '0, 1'b0);

      setAllReady();
      readyOff[5] = 13;
      runBlock({$urandom(), $urandom(), $urandom(), $urandom()}, key, 1'b0, 1'b0, '0, 1'b0);

      // Reset while the core works on round 4.
      setAllReady();
      expandKey(FIPS_KEY);
      for (int n = 0; n < 11; n++) rk[n] = modelRk[n];
      t0 = cycleCnt;
      iData = FIPS_PT;
      iLastBlock = 1'b1;
      iStart = 1'b1;
      iKeyRoundReady = '1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      while (cycleCnt < t0 + 5) begin
         @(posedge iClk); #1;
      end
      iRst = 1'b1;
      #1;
      check("abort oBusy", oBusy, 1'b0);
      check("abort oDone", oDone, 1'b0);
      check("abort oData", oData, '0);
      check("abort oKeyEnd", oKeyEnd, 1'b0);
`ifdef AES128_STALL_CNT_EN
      check("abort stall count", oStallCnt, '0);
`endif
      @(posedge iClk); #1;
      iRst = 1'b0;
      prevData = '0;

      setAllReady();
      runBlock('0, '0, 1'b0, 1'b1, ZERO_CT, 1'b0);

      for (int b = 0; b < 8; b++) begin
         readyOff[0] = int'($urandom_range(0, 3));
         for (int n = 1; n < 11; n++) readyOff[n] = readyOff[n - 1] + int'($urandom_range(0, 2));
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         runBlock(pt, key, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge iClk); #1;
         end
      end

      repeat (3) @(posedge iClk);
      #1;
      check("scoreboard drained", 128'(sb.size()), '0);
      check("oDone count", 128'(nDone), 128'(nExpected));
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/aes128_cipher_core.md
Name: aes128_cipher_core

Overview:
- Iterative AES-128 encryption engine; consumes the 11 round keys and per-round ready flags produced by the key expansion stage directly upstream.
- Runs one round per clock and stalls on any round whose key is not yet ready.
- Signals end-of-key-use back upstream so key expansion can return to idle.

Parameters:
- NR, 10, number of rounds; fixed for AES-128; any other value is illegal.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE.
- iLastBlock  input  1  sampled with iStart; marks the last block under the current key.
- iData  input  128  plaintext; column c = iData[32c+31:32c], row r = [32c+8r+7:32c+8r] (same word/byte packing as the round keys).
- iKeyRoundReady  input  11  per-round key valid flags, bit n = round n.
- iKeyRound00..iKeyRound10  input  128 each  round keys 0..10.
- oBusy  output  1  high from start acceptance through the oDone cycle.
- oDone  output  1  one-cycle pulse; oData is valid from this cycle on.
- oData  output  128  ciphertext, same packing as iData; held until the next oDone.
- oKeyEnd  output  1  one-cycle pulse, coincident with oDone, only if iLastBlock was set at start; wired to key expansion iEnd.

Behaviour:
- Reset (async, iRst=1): state IDLE, rnd=0, state register=0, oBusy=0, oDone=0, oData=0, oKeyEnd=0.
- Reset mid-operation aborts the block immediately; no oDone.
- FSM IDLE -> RUN -> DONE -> IDLE (one-hot, 3 bits).
- IDLE:
  - iStart=1: latch iData into the state register, latch iLastBlock, rnd<=0, oBusy<=1, go to RUN.
  - iStart=0: stay in IDLE.
- RUN, per cycle:
  - iKeyRoundReady[rnd]=0: stall; state register and rnd hold.
  - rnd=0 and key ready: state ^= iKeyRound00.
  - rnd=1..9 and key ready: SubBytes, ShiftRows, MixColumns, AddRoundKey(iKeyRound[rnd]).
  - rnd=10 and key ready: SubBytes, ShiftRows, AddRoundKey(iKeyRound10); no MixColumns.
  - After each completed round rnd increments.
  - Round 10 completing moves the FSM to DONE and registers the result into oData.
- DONE, single cycle:
  - oDone=1; oKeyEnd=latched iLastBlock.
  - oBusy still 1 this cycle.
  - Next cycle: IDLE, oBusy=0.
- iStart while oBusy=1 is ignored; no queueing.
- A new iStart is accepted in the first IDLE cycle after DONE.
- Latency with all keys ready: iStart cycle T, oDone at T+12; minimum block period 13 cycles.
- Stall cycles add 1:1 to latency.
- Key flags are sampled every RUN cycle. Key expansion clearing flags mid-block (it returned to idle) stalls the core; no other recovery.
- GF(2^8) arithmetic uses reduction polynomial 0x11B (xtime).
- ShiftRows rotates row r left by r columns.

Optional Feature:
- Macro AES128_STALL_CNT_EN.
- Defined:
  - Adds output oStallCnt [STALL_CNT_W-1:0].
  - Counts RUN cycles with iKeyRoundReady[rnd]=0.
  - Cleared on reset and on start acceptance.
  - Saturates at all-ones; holds its value after DONE.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Decomposition:
- Package aes128_pkg:
  - S-box constant array.
  - xtime and gf-mul2/mul3 functions.
  - 128-bit state typedef and column/byte index helpers.
  - NR constant.
  - One-hot FSM state encodings.
- Sub-module aes128_round: combinational.
  - Inputs: state, round key, final flag.
  - Output: next state.
  - Instantiated once; the core holds only FSM, counters and registers.

Test Plan:
- FIPS-197 C.1: key bytes 00..0f (128'h0f0e0d0c0b0a09080706050403020100); all ready flags high; iData=128'hffeeddccbbaa99887766554433221100 -> oDone at T+12, oData=128'h5ac5b47080b7cdd830047b6ad8e0c469, oKeyEnd=iLastBlock.
- Ready flags rise one per cycle, driven by a live key expansion instance started in the same cycle -> same ciphertext; latency = 12 + stall count; with AES128_STALL_CNT_EN, oStallCnt matches the bench count.
- Back-to-back: two blocks under the same key, first with iLastBlock=0, second with 1; second iStart issued while oBusy=1, then reissued after -> busy iStart ignored, reissued start accepted; oKeyEnd pulses only with the second oDone.
- Hold iKeyRoundReady[5]=0 for 7 cycles -> oBusy stays high, oData unchanged, result correct after release; stall count = 7.
- Assert iRst at rnd=4 -> oBusy=0, oDone never pulses, oData=0 immediately; a subsequent block encrypts correctly.
- Plaintext all-zero, key all-zero -> oData packs ciphertext bytes 66e94bd4ef8a2c3b884cfa59ca342b2e (LSB-first).
